// File: rtl/ysyx_23060077_ifid_queue_pkg.sv
// Shared constants for the IF/ID decoupling queue: data width, RV32 opcodes
// used by predecode, and the predecode flag layout stored with each entry.
package ysyx_23060077_ifid_queue_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [2:0] FUNCT3_FENCE_I = 3'b001;

  // Each queue entry is {pc, inst, pdc}; pc/inst width follows the top's DATA_WIDTH.
  typedef struct packed {
    logic jump;
    logic fence_i;
  } pdc_t;

endpackage

// File: rtl/ysyx_23060077_inst_predecode.sv
// Combinational predecode of an RV32 instruction into control-flow and fence.i
// flags; only opcode and funct3 are needed, so only those bits are taken.
module ysyx_23060077_inst_predecode (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  output logic       jump_o,
  output logic       fence_i_o
);
  import ysyx_23060077_ifid_queue_pkg::*;

  assign jump_o    = (opcode_i == OPC_JAL) | (opcode_i == OPC_JALR) | (opcode_i == OPC_BRANCH);
  assign fence_i_o = (opcode_i == OPC_MISC_MEM) & (funct3_i == FUNCT3_FENCE_I);

endmodule

// File: rtl/ysyx_23060077_ifid_queue.sv
// IF->ID decoupling FIFO: in-order, first-word-fall-through head, predecode at
// enqueue, flush on redirect. Full/empty are told apart by the occupancy count.
module ysyx_23060077_ifid_queue #(
  parameter  int DEPTH      = 2,
  parameter  int DATA_WIDTH = ysyx_23060077_ifid_queue_pkg::DATA_WIDTH,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_pc_i,
  input  logic [DATA_WIDTH-1:0] in_inst_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_pc_o,
  output logic [DATA_WIDTH-1:0] out_inst_o,
  output logic                  out_jump_o,
  output logic                  out_fence_i_o,
  output logic [CNT_W-1:0]      count_o
);
  import ysyx_23060077_ifid_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] pc_q, pc_d, inst_q, inst_d;
  pdc_t [DEPTH-1:0]                 pdc_q, pdc_d;
  logic                             in_jump, in_fence_i;
  logic                             enq, deq;

  ysyx_23060077_inst_predecode u_predecode (
    .opcode_i  (in_inst_i[6:0]),
    .funct3_i  (in_inst_i[14:12]),
    .jump_o    (in_jump),
    .fence_i_o (in_fence_i)
  );

  // Ready never looks at out_ready_i, so a full queue stalls the IFU for a cycle
  // even when the IDU drains; this keeps the IFU-side path short.
  assign in_ready_o  = (count_q < CNT_W'(DEPTH)) & ~flush_i;
  assign out_valid_o = (count_q != '0);
  assign enq         = in_valid_i & in_ready_o;
  assign deq         = out_valid_o & out_ready_i;

  assign out_pc_o      = pc_q[rd_ptr_q];
  assign out_inst_o    = inst_q[rd_ptr_q];
  assign out_jump_o    = pdc_q[rd_ptr_q].jump;
  assign out_fence_i_o = pdc_q[rd_ptr_q].fence_i;
  assign count_o       = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pdc_d    = pdc_q;
    if (enq) begin
      pc_d[wr_ptr_q]          = in_pc_i;
      inst_d[wr_ptr_q]        = in_inst_i;
      pdc_d[wr_ptr_q].jump    = in_jump;
      pdc_d[wr_ptr_q].fence_i = in_fence_i;
    end
    // Flush resets bookkeeping only; stale storage is unreachable once count=0.
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= '0;
      inst_q   <= '0;
      pdc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pdc_q    <= pdc_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_ifid_queue.sv
// Scoreboard bench for the IF/ID queue: inputs change on the falling edge, the
// model decides each handshake just before the next rising edge.
module tb_ysyx_23060077_ifid_queue;

  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] inst;
    logic          jump;
    logic          fence_i;
  } ent_t;

  logic          clock, reset, flush_i, in_valid_i, in_ready_o;
  logic [DW-1:0] in_pc_i, in_inst_i, out_pc_o, out_inst_o;
  logic          out_valid_o, out_ready_i, out_jump_o, out_fence_i_o;
  logic [CW-1:0] count_o;

  ent_t sb[$];
  int   n_chk = 0, n_err = 0, n_deq = 0;
  logic acc;

  ysyx_23060077_ifid_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
    .out_jump_o(out_jump_o), .out_fence_i_o(out_fence_i_o),
    .count_o(count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [DW-1:0] pc, input logic [DW-1:0] inst);
    ent_t e;
    logic [6:0] op;
    op        = inst[6:0];
    e.pc      = pc;
    e.inst    = inst;
    e.jump    = (op == 7'h6f) || (op == 7'h67) || (op == 7'h63);
    e.fence_i = (op == 7'h0f) && (inst[14:12] == 3'd1);
    return e;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic tick();
    logic exp_rdy;
    ent_t e;
    #1;
    exp_rdy = (sb.size() < DEPTH) && !flush_i;
    chk("in_ready", in_ready_o, exp_rdy);
    chk("out_valid", out_valid_o, sb.size() != 0);
    chk("count", count_o, sb.size());
    if (sb.size() != 0) begin
      e = sb[0];
      chk("head_pc", out_pc_o, e.pc);
      chk("head_inst", out_inst_o, e.inst);
      chk("head_jump", out_jump_o, e.jump);
      chk("head_fence", out_fence_i_o, e.fence_i);
      if (out_ready_i) begin
        void'(sb.pop_front());
        n_deq++;
      end
    end
    acc = 1'b0;
    if (flush_i) sb.delete();
    else if (in_valid_i && exp_rdy) begin
      sb.push_back(mk(in_pc_i, in_inst_i));
      acc = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic push(input logic [DW-1:0] pc, input logic [DW-1:0] inst);
    int n;
    in_valid_i = 1'b1;
    in_pc_i    = pc;
    in_inst_i  = inst;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 6) begin
      tick();
      n++;
    end
    chk("push_accepted", acc, 1'b1);
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
    chk("drain_empty", sb.size(), 0);
    out_ready_i = 1'b0;
    tick();
  endtask

  initial begin
    int base_deq;
    reset = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_pc_i = '0; in_inst_i = '0;
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_pc", out_pc_o, 0);
    chk("rst_inst", out_inst_o, 0);
    chk("rst_flags", {out_jump_o, out_fence_i_o}, 0);
    chk("rst_count", count_o, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // single push into empty queue, visible next cycle
    push(32'h3000_0000, 32'h0000_0013);
    #1;
    chk("first_valid", out_valid_o, 1);
    chk("first_pc", out_pc_o, 32'h3000_0000);
    chk("first_count", count_o, 1);
    chk("first_jump", out_jump_o, 0);
    drain();

    // full queue: a write is refused even while the head is dequeued
    push(32'h3000_0000, 32'h0000_0013);
    push(32'h3000_0004, 32'h0000_0013);
    in_valid_i = 1'b1; in_pc_i = 32'h3000_0008; in_inst_i = 32'h0000_0013;
    out_ready_i = 1'b1;
    tick();
    chk("full_no_write", acc, 0);
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    #1;
    chk("full_count", count_o, 1);
    chk("full_head", out_pc_o, 32'h3000_0004);
    drain();

    // streaming across pointer wrap
    base_deq = n_deq;
    out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push(32'h3000_0000 + 32'(4 * k), 32'h0000_0013 | (32'(k) << 20));
      chk("stream_cnt_le2", count_o <= 2, 1);
    end
    drain();
    chk("stream_deq_total", n_deq - base_deq, 8);

    // flush drops entries and the concurrent input
    push(32'h3000_0010, 32'h0000_0013);
    push(32'h3000_0014, 32'h0000_0013);
    flush_i = 1'b1; in_valid_i = 1'b1;
    in_pc_i = 32'h8000_0000; in_inst_i = 32'h0000_0013;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    #1;
    chk("flush_count", count_o, 0);
    chk("flush_valid", out_valid_o, 0);
    push(32'h8000_0000, 32'h0000_0013);
    #1;
    chk("post_flush_valid", out_valid_o, 1);
    chk("post_flush_pc", out_pc_o, 32'h8000_0000);
    drain();

    // predecode flags in order
    push(32'h3000_0100, 32'h0000_100F);
    push(32'h3000_0104, 32'h0080_00EF);
    #1;
    chk("fencei_head_f", out_fence_i_o, 1);
    chk("fencei_head_j", out_jump_o, 0);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    #1;
    chk("jal_head_j", out_jump_o, 1);
    chk("jal_head_f", out_fence_i_o, 0);
    drain();
    push(32'h3000_0108, 32'h0000_0463);
    #1;
    chk("beq_head_j", out_jump_o, 1);
    drain();

    // asynchronous reset between clock edges
    push(32'h3000_0200, 32'h0000_0013);
    push(32'h3000_0204, 32'h0000_0013);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_count", count_o, 0);
    chk("arst_pc", out_pc_o, 0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    tick();
    push(32'h3000_0300, 32'h0000_0067);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
